traffic_countdown_bcd: RTL and testbench

- Phase-duration countdown timer for the traffic-light controller.
- Loads a phase time in seconds (binary) and decrements it once per second.
- Presents the remaining time as two BCD digits (tens, units); each digit drives one 7-segment decoder directly.
- Flags phase completion to the light FSM with a one-cycle done pulse.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/traffic_countdown_bcd.sv | 85 ++++++++
 tb/tb_traffic_countdown_bcd.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller blocks.
// Phase durations are in seconds and are fed to the countdown's load_val.
package traffic_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned MAX_SECONDS = 99;

    localparam logic [6:0] GREEN_S  = 7'd30;
    localparam logic [6:0] YELLOW_S = 7'd4;
    localparam logic [6:0] RED_S    = 7'd25;

    // Two BCD digits can only show 00..99, so longer phases are clipped.
    function automatic logic [6:0] sat_seconds(input logic [6:0] secs);
        logic [6:0] max_s;
        max_s = 7'(MAX_SECONDS);
        return (secs > max_s) ? max_s : secs;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every DIV cycles of run.
// The count holds while run is low and is cleared synchronously by clr.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("tick_prescaler: DIV must be >= 2");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = run && w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_countdown_bcd.sv
// Phase countdown timer: loads seconds, decrements once per tick and shows the
// remaining time as two BCD digits; pulses done when the count reaches 00.
module traffic_countdown_bcd
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       enable,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;

    bcd_t       r_tens;
    bcd_t       r_units;
    logic       r_busy;
    logic       r_done;

    logic       w_run;
    logic       w_tick;
    logic [6:0] w_sat;
    bcd_t       w_load_tens;
    bcd_t       w_load_units;
    logic       w_at_one;

    assign w_run = r_busy && enable;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .run   (w_run),
        .tick  (w_tick)
    );

    assign w_sat        = sat_seconds(load_val);
    assign w_load_tens  = 4'(w_sat / 7'd10);
    assign w_load_units = 4'(w_sat % 7'd10);
    assign w_at_one     = (r_tens == 4'd0) && (r_units == 4'd1);

    // Load wins over a same-cycle tick, so an aborted count never raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_tens  <= w_load_tens;
            r_units <= w_load_units;
            r_busy  <= (w_sat != 7'd0);
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                if (r_units != 4'd0) begin
                    r_units <= r_units - 4'd1;
                end else begin
                    r_units <= 4'd9;
                    r_tens  <= r_tens - 4'd1;
                end
                if (w_at_one) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign tens  = r_tens;
    assign units = r_units;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_traffic_countdown_bcd.sv
// Bench for traffic_countdown_bcd: directed vector table, hand-written reset and
// pause sequences, then random stimulus against a seconds-level reference model.
module tb_traffic_countdown_bcd;

    localparam int unsigned CLK_HZ = 10;
    localparam int unsigned TICK   = 1;
    localparam int unsigned DIV    = CLK_HZ / TICK;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [6:0] load_val;
    logic       enable;
    logic [3:0] tens;
    logic [3:0] units;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining seconds as a plain integer.
    int m_val   = 0;
    int m_phase = 0;
    bit m_busy  = 0;
    bit m_done  = 0;

    typedef struct {
        bit         ld;
        logic [6:0] lv;
        bit         en;
        int         n;
        logic [3:0] et;
        logic [3:0] eu;
        bit         eb;
        bit         ed;
    } vec_t;

    vec_t vecs[$];

    traffic_countdown_bcd #(
        .CLK_FREQ_HZ (CLK_HZ),
        .TICK_HZ     (TICK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .enable   (enable),
        .tens     (tens),
        .units    (units),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_val   = 0;
        m_phase = 0;
        m_busy  = 0;
        m_done  = 0;
    endfunction

    function automatic void model_step(input bit ld, input int lv, input bit en);
        m_done = 0;
        if (ld) begin
            m_val   = (lv > 99) ? 99 : lv;
            m_phase = 0;
            m_busy  = (m_val != 0);
        end else if (m_busy && en) begin
            if (m_phase == int'(DIV) - 1) begin
                m_phase = 0;
                m_val   = m_val - 1;
                if (m_val == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [3:0] et, input logic [3:0] eu,
                         input logic eb, input logic ed);
        checks++;
        if ({tens, units, busy, done} !== {et, eu, eb, ed}) begin
            errors++;
            $display("FAIL %s: got %0d/%0d busy=%0b done=%0b, want %0d/%0d busy=%0b done=%0b",
                     name, tens, units, busy, done, et, eu, eb, ed);
        end
    endtask

    task automatic check_model(input string name);
        check(name, 4'(m_val / 10), 4'(m_val % 10), m_busy, m_done);
    endtask

    // Called at a negedge: drive inputs, take one posedge, return at the next negedge.
    task automatic step(input bit ld, input logic [6:0] lv, input bit en);
        load     = ld;
        load_val = lv;
        enable   = en;
        @(posedge clk);
        model_step(ld, int'(lv), en);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        load_val = 7'd0;
        enable   = 1'b0;
        #12;
        check("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //              ld  lv       en  n   tens  units busy done
        vecs.push_back('{1, 7'd25,  1,  1, 4'd2, 4'd5, 1, 0});
        vecs.push_back('{0, 7'd0,   1, 10, 4'd2, 4'd4, 1, 0});
        vecs.push_back('{0, 7'd0,   1, 50, 4'd1, 4'd9, 1, 0});
        vecs.push_back('{1, 7'd3,   1,  1, 4'd0, 4'd3, 1, 0});
        vecs.push_back('{0, 7'd0,   1, 29, 4'd0, 4'd1, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  1, 4'd0, 4'd0, 0, 1});
        vecs.push_back('{0, 7'd0,   1,  1, 4'd0, 4'd0, 0, 0});
        vecs.push_back('{0, 7'd0,   1, 49, 4'd0, 4'd0, 0, 0});
        vecs.push_back('{1, 7'd120, 1,  1, 4'd9, 4'd9, 1, 0});
        vecs.push_back('{1, 7'd0,   1,  1, 4'd0, 4'd0, 0, 0});
        vecs.push_back('{0, 7'd0,   1,  5, 4'd0, 4'd0, 0, 0});
        vecs.push_back('{1, 7'd5,   1,  1, 4'd0, 4'd5, 1, 0});
        vecs.push_back('{0, 7'd0,   1, 14, 4'd0, 4'd4, 1, 0});
        vecs.push_back('{0, 7'd0,   0, 25, 4'd0, 4'd4, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  5, 4'd0, 4'd4, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  1, 4'd0, 4'd3, 1, 0});
        vecs.push_back('{1, 7'd9,   1,  1, 4'd0, 4'd9, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  9, 4'd0, 4'd9, 1, 0});
        vecs.push_back('{1, 7'd42,  1,  1, 4'd4, 4'd2, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  9, 4'd4, 4'd2, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  1, 4'd4, 4'd1, 1, 0});
        vecs.push_back('{1, 7'd1,   1,  1, 4'd0, 4'd1, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  9, 4'd0, 4'd1, 1, 0});
        vecs.push_back('{1, 7'd7,   1,  1, 4'd0, 4'd7, 1, 0});
        vecs.push_back('{0, 7'd0,   1,  1, 4'd0, 4'd7, 1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                step((c == 0) ? vecs[i].ld : 1'b0, vecs[i].lv, vecs[i].en);
            end
            check($sformatf("vec%0d", i), vecs[i].et, vecs[i].eu, vecs[i].eb, vecs[i].ed);
        end

        // Pause must hold the digits on every cycle, not just at the end.
        step(1'b1, 7'd5, 1'b1);
        for (int c = 0; c < 14; c++) step(1'b0, 7'd0, 1'b1);
        for (int c = 0; c < 25; c++) begin
            step(1'b0, 7'd0, 1'b0);
            check("pause_hold", 4'd0, 4'd4, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-count, observed before the next rising edge.
        step(1'b1, 7'd50, 1'b1);
        for (int c = 0; c < 13; c++) step(1'b0, 7'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 7'd0, 1'b1);
            check("idle_after_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        end

        // Random stimulus against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit         ld;
            bit         en;
            logic [6:0] lv;
            ld = ($urandom_range(0, 39) == 0);
            en = ($urandom_range(0, 4) != 0);
            lv = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                             : 7'($urandom_range(0, 6));
            step(ld, lv, en);
            check_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
